uart_tx_fifo: RTL and testbench

RS-232 UART transmitter that serialises bytes onto the `rs232_tx` line in 8N1 format: one start bit, 8 data bits LSB first, one stop bit. It is the transmit end of the UART link: the receiver samples incoming bits at mid-bit, and this block drives the line for exactly one bit period per bit. It contains its own bit-period counter and a 4-entry byte FIFO, so upstream logic can queue short bursts with a valid/ready handshake. It sits between the system data path and the board RS-232 pin.

---
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a 4-entry byte FIFO and valid/ready upload port.
// The serial line and busy flag are registered, so both lag the FSM state by one clock.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 5208,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       rs232_tx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [12:0] CNT_LAST   = 13'(CLK_DIV - 1);
    localparam logic [2:0]  COUNT_FULL = 3'(FIFO_DEPTH);

    logic [7:0]  mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        push;
    logic        pop;

    state_t      state;
    state_t      state_nx;
    logic [12:0] cnt;
    logic [12:0] cnt_nx;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_nx;
    logic [7:0]  shift;
    logic [7:0]  shift_nx;
    logic        line_nx;
    logic        bit_end;

    assign tx_ready = (count != COUNT_FULL);
    assign push     = tx_valid && tx_ready;
    assign bit_end  = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 13'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            rs232_tx <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_idx  <= bit_idx_nx;
            shift    <= shift_nx;
            rs232_tx <= line_nx;
            tx_busy  <= (state != IDLE) || (count != 3'd0);
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        pop        = 1'b0;
        line_nx    = 1'b1;
        case (state)
            IDLE: begin
                cnt_nx = 13'd0;
                if (count != 3'd0) begin
                    pop      = 1'b1;
                    shift_nx = mem[rd_ptr];
                    state_nx = START;
                end
            end
            START: begin
                line_nx = 1'b0;
                cnt_nx  = bit_end ? 13'd0 : cnt + 13'd1;
                if (bit_end) begin
                    bit_idx_nx = 3'd0;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                line_nx = shift[0];
                cnt_nx  = bit_end ? 13'd0 : cnt + 13'd1;
                if (bit_end) begin
                    shift_nx   = {1'b0, shift[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                cnt_nx = bit_end ? 13'd0 : cnt + 13'd1;
                if (bit_end) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (divisors 16, default, 2) checked per cycle
// against a frame-timing model built from queue contents and frame start times.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] data_a, data_b, data_c;
    logic       valid_a, valid_b, valid_c;
    logic       ready_a, ready_b, ready_c;
    logic       busy_a, busy_b, busy_c;
    logic       line_a, line_b, line_c;

    uart_tx_fifo #(.CLK_DIV(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .tx_busy(busy_a), .rs232_tx(line_a));

    uart_tx_fifo dut_def (
        .clk(clk), .rst_n(rst_n), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .tx_busy(busy_b), .rs232_tx(line_b));

    uart_tx_fifo #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_c), .tx_valid(valid_c),
        .tx_ready(ready_c), .tx_busy(busy_c), .rs232_tx(line_c));

    logic [1:0] sel;
    int         div;
    logic       obs_line, obs_ready, obs_busy;

    always_comb begin
        obs_line  = line_a;
        obs_ready = ready_a;
        obs_busy  = busy_a;
        case (sel)
            2'd1: begin obs_line = line_b; obs_ready = ready_b; obs_busy = busy_b; end
            2'd2: begin obs_line = line_c; obs_ready = ready_c; obs_busy = busy_c; end
            default: ;
        endcase
    end

    // Reference model: bytes waiting in the FIFO, and the edge of the most recent pop.
    logic [7:0] q[$];
    bit         have;
    longint     pop_edge;
    logic [7:0] cur_byte;
    longint     cyc;
    logic       exp_line, exp_ready, exp_busy, busy_pend;
    int         checks, errors;

    task automatic reset_model();
        q.delete();
        have      = 1'b0;
        pop_edge  = 0;
        busy_pend = 1'b0;
        exp_line  = 1'b1;
        exp_ready = 1'b1;
        exp_busy  = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        valid_a = (sel == 2'd0) && v;
        valid_b = (sel == 2'd1) && v;
        valid_c = (sel == 2'd2) && v;
        data_a = d;
        data_b = d;
        data_c = d;
    endtask

    // Called at a negedge; advances one clock and leaves expected values for the next negedge.
    task automatic tick(input logic v, input logic [7:0] d);
        int         cb;
        int         k;
        bit         act;
        logic [9:0] frame;
        drive(v, d);
        @(posedge clk);
        cyc++;
        cb = q.size();
        if (cb > 0 && (!have || cyc >= pop_edge + 10 * div + 1)) begin
            cur_byte = q.pop_front();
            pop_edge = cyc;
            have     = 1'b1;
        end
        if (v && cb < 4) q.push_back(d);
        exp_busy  = busy_pend;
        act       = have && cyc >= pop_edge && cyc < pop_edge + 10 * div;
        busy_pend = act || (q.size() != 0);
        exp_ready = (q.size() < 4);
        exp_line  = 1'b1;
        if (have && cyc >= pop_edge + 1 && cyc < pop_edge + 1 + 10 * div) begin
            k        = int'((cyc - pop_edge - 1) / div);
            frame    = {1'b1, cur_byte, 1'b0};
            exp_line = frame[k];
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        reset_model();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        do_reset();
        got = {line_a, ready_a, busy_a, line_b, ready_b, busy_b, line_c, ready_c, busy_c};
        checks++;
        if (got !== 9'b110_110_110) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", got, 9'b110_110_110);
        end
    endtask

    task automatic test_single();
        longint n, fall, bfall;
        bit     seen_busy;
        sel = 2'd0; div = 16;
        do_reset();
        tick(1'b1, 8'h55);
        n = cyc; fall = -1; bfall = -1; seen_busy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1'b0, 8'h00);
            checks++;
            if ({obs_line, obs_ready, obs_busy} !== {exp_line, exp_ready, exp_busy}) begin
                errors++;
                $display("FAIL single cyc=%0d got=%b exp=%b", cyc,
                         {obs_line, obs_ready, obs_busy}, {exp_line, exp_ready, exp_busy});
            end
            if (fall < 0 && obs_line == 1'b0) fall = cyc;
            if (obs_busy) seen_busy = 1'b1;
            if (seen_busy && bfall < 0 && !obs_busy) bfall = cyc;
        end
        checks++;
        if (fall !== n + 2) begin
            errors++;
            $display("FAIL single_start_latency got=%0d exp=%0d", fall - n, 2);
        end
        checks++;
        if (bfall !== n + 162) begin
            errors++;
            $display("FAIL single_busy_fall got=%0d exp=%0d", bfall - n, 162);
        end
    endtask

    task automatic test_burst();
        int     idx, accepts, drop_accepts;
        longint n, rel;
        logic   prev_line;
        bit     acc;
        sel = 2'd0; div = 16;
        do_reset();
        idx = 1; accepts = 0; drop_accepts = -1; n = cyc + 1; prev_line = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            acc = obs_ready && (idx <= 6);
            tick(idx <= 6, 8'(idx));
            if (acc) begin idx++; accepts++; end
            checks++;
            if ({obs_line, obs_ready, obs_busy} !== {exp_line, exp_ready, exp_busy}) begin
                errors++;
                $display("FAIL burst cyc=%0d got=%b exp=%b", cyc,
                         {obs_line, obs_ready, obs_busy}, {exp_line, exp_ready, exp_busy});
            end
            if (drop_accepts < 0 && !obs_ready) drop_accepts = accepts;
            rel = cyc - (n + 2);
            if (rel >= 0 && rel % 161 == 0 && rel / 161 < 6) begin
                checks++;
                if ({prev_line, obs_line} !== 2'b10) begin
                    errors++;
                    $display("FAIL burst_start_edge frame=%0d got=%b exp=%b", rel / 161,
                             {prev_line, obs_line}, 2'b10);
                end
            end
            prev_line = obs_line;
        end
        checks++;
        if (drop_accepts != 5) begin
            errors++;
            $display("FAIL burst_ready_drop got=%0d exp=%0d", drop_accepts, 5);
        end
        checks++;
        if (accepts != 6) begin
            errors++;
            $display("FAIL burst_accepts got=%0d exp=%0d", accepts, 6);
        end
    endtask

    task automatic test_ignored();
        sel = 2'd0; div = 16;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h10 + i));
        tick(1'b0, 8'h00);
        tick(1'b1, 8'hAA);
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignored_ready got=%b exp=%b", obs_ready, 1'b0);
        end
        for (int i = 0; i < 900; i++) begin
            tick(1'b0, 8'h00);
            checks++;
            if ({obs_line, obs_ready, obs_busy} !== {exp_line, exp_ready, exp_busy}) begin
                errors++;
                $display("FAIL ignored cyc=%0d got=%b exp=%b", cyc,
                         {obs_line, obs_ready, obs_busy}, {exp_line, exp_ready, exp_busy});
            end
        end
    endtask

    task automatic test_reset_mid();
        longint n;
        int     lows;
        sel = 2'd0; div = 16;
        do_reset();
        tick(1'b1, 8'hF0);
        n = cyc;
        tick(1'b1, 8'hA5);
        tick(1'b1, 8'h3C);
        while (cyc < n + 2 + 16 * 4 + 8) tick(1'b0, 8'h00);
        checks++;
        if (obs_line !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_bit3 got=%b exp=%b", obs_line, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({obs_line, obs_ready, obs_busy} !== 3'b110) begin
            errors++;
            $display("FAIL reset_mid_async got=%b exp=%b", {obs_line, obs_ready, obs_busy}, 3'b110);
        end
        repeat (2) @(negedge clk);
        reset_model();
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1'b0, 8'h00);
            if (!obs_line) lows++;
            checks++;
            if ({obs_line, obs_ready, obs_busy} !== {exp_line, exp_ready, exp_busy}) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", cyc,
                         {obs_line, obs_ready, obs_busy}, {exp_line, exp_ready, exp_busy});
            end
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL reset_mid_residual got=%0d exp=%0d", lows, 0);
        end
    endtask

    task automatic test_default();
        longint n, first_low;
        int     lows;
        sel = 2'd1; div = 5208;
        do_reset();
        tick(1'b1, 8'h00);
        n = cyc; first_low = -1; lows = 0;
        for (int i = 0; i < 52090; i++) begin
            tick(1'b0, 8'h00);
            if (!obs_line) begin
                lows++;
                if (first_low < 0) first_low = cyc;
            end
            checks++;
            if ({obs_line, obs_ready, obs_busy} !== {exp_line, exp_ready, exp_busy}) begin
                errors++;
                $display("FAIL default cyc=%0d got=%b exp=%b", cyc,
                         {obs_line, obs_ready, obs_busy}, {exp_line, exp_ready, exp_busy});
            end
        end
        checks++;
        if (lows != 46872) begin
            errors++;
            $display("FAIL default_low_len got=%0d exp=%0d", lows, 46872);
        end
        checks++;
        if (first_low !== n + 2) begin
            errors++;
            $display("FAIL default_start got=%0d exp=%0d", first_low - n, 2);
        end
    endtask

    task automatic test_boundary();
        longint      n;
        logic [40:0] trace, want;
        sel = 2'd2; div = 2;
        do_reset();
        tick(1'b1, 8'hFF);
        n = cyc;
        tick(1'b1, 8'h80);
        for (int i = 0; i < 41; i++) want[i] = !(i < 2 || (i >= 21 && i < 37));
        trace = '1;
        for (int i = 0; i < 60; i++) begin
            tick(1'b0, 8'h00);
            if (cyc >= n + 2 && cyc < n + 43) trace[int'(cyc - n - 2)] = obs_line;
            checks++;
            if ({obs_line, obs_ready, obs_busy} !== {exp_line, exp_ready, exp_busy}) begin
                errors++;
                $display("FAIL boundary cyc=%0d got=%b exp=%b", cyc,
                         {obs_line, obs_ready, obs_busy}, {exp_line, exp_ready, exp_busy});
            end
        end
        checks++;
        if (trace !== want) begin
            errors++;
            $display("FAIL boundary_trace got=%b exp=%b", trace, want);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [7:0] d;
        sel = 2'd0; div = 16;
        do_reset();
        for (int i = 0; i < 3600; i++) begin
            v = (i < 2800) && ($urandom_range(0, 11) == 0);
            d = 8'($urandom);
            tick(v, d);
            checks++;
            if ({obs_line, obs_ready, obs_busy} !== {exp_line, exp_ready, exp_busy}) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc,
                         {obs_line, obs_ready, obs_busy}, {exp_line, exp_ready, exp_busy});
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sel    = 2'd0;
        div    = 16;
        cyc    = 0;
        checks = 0;
        errors = 0;
        drive(1'b0, 8'h00);
        reset_model();
        test_reset();
        test_single();
        test_burst();
        test_ignored();
        test_reset_mid();
        test_boundary();
        test_random();
        test_default();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
